// File: rtl/sd_cmd_rsp_rx_if.sv
// ---------------------------------------------------------------------------
// sd_cmd_rsp_rx_if
// Bundle between the SD host controller FSM (master) and the CMD-line
// response receiver (slave).
//
// Handshake: start is a request and !busy is its ready. A start pulse is
// taken only in a cycle where busy=0 and done=0. The result appears with a
// one-cycle done pulse. rsp_* and the flags are valid from that cycle and
// hold until the next done.
//
//   bit_en     master->slave  sample strobe (SD clock edge)
//   cmd_in     master->slave  synchronised CMD line level
//   start      master->slave  arm receiver
//   long_rsp   master->slave  1 = 136-bit R2 frame, sampled with start
//   skip_crc   master->slave  1 = ignore CRC field, sampled with start
//   busy       slave->master  receiver armed or receiving
//   done       slave->master  one-cycle completion pulse
//   rsp_index  slave->master  command index / reserved field
//   rsp_data   slave->master  argument or CID/CSD bits
//   crc_err    slave->master  CRC7 mismatch
//   frame_err  slave->master  bad transmission or end bit
//   timeout    slave->master  no start bit arrived in time
// ---------------------------------------------------------------------------
interface sd_cmd_rsp_rx_if;
    logic         bit_en;
    logic         cmd_in;
    logic         start;
    logic         long_rsp;
    logic         skip_crc;
    logic         busy;
    logic         done;
    logic [5:0]   rsp_index;
    logic [127:0] rsp_data;
    logic         crc_err;
    logic         frame_err;
    logic         timeout;

    modport master (
        output bit_en, cmd_in, start, long_rsp, skip_crc,
        input  busy, done, rsp_index, rsp_data, crc_err, frame_err, timeout
    );

    modport slave (
        input  bit_en, cmd_in, start, long_rsp, skip_crc,
        output busy, done, rsp_index, rsp_data, crc_err, frame_err, timeout
    );
endinterface

// File: rtl/sd_cmd_rsp_rx.sv
// ---------------------------------------------------------------------------
// sd_cmd_rsp_rx
// Receives SD command responses on the CMD line: 48-bit (R1/R3/R6/R7) and
// 136-bit (R2). It hunts for the start bit and shifts the frame in MSB
// first. It checks CRC7 (x^7+x^3+1, init 0) and the transmission and end
// bits, then reports the decoded fields with a one-cycle done pulse.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous reset, active low
//   bus      sd_cmd_rsp_rx_if.slave (strobe, line, request, results)
//   state_o  current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module sd_cmd_rsp_rx #(
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    sd_cmd_rsp_rx_if.slave  bus,
    output logic [2:0]      state_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CRC  = 3'd3;
    localparam logic [2:0] S_STOP = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]   state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;        // timeout count in WAIT, frame bit count after
    logic [135:0] sh_q, sh_d;
    logic [6:0]   crc_q, crc_d;
    logic         long_q, long_d;
    logic         skip_q, skip_d;
    logic         ferr_q, ferr_d;      // frame error gathered during the frame
    logic [5:0]   idx_q, idx_d;
    logic [127:0] data_q, data_d;
    logic         crc_err_q, crc_err_d;
    logic         frame_err_q, frame_err_d;
    logic         timeout_q, timeout_d;

    logic [135:0] sh_shift;
    logic         crc_fb;
    logic [6:0]   crc_step;
    logic [7:0]   data_last;
    logic [7:0]   crc_last;

    assign sh_shift  = (sh_q << 1) | {135'b0, bus.cmd_in};
    assign crc_fb    = crc_q[6] ^ bus.cmd_in;
    assign crc_step  = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
    // Value of cnt_q on the strobe that carries the last data / last CRC bit.
    assign data_last = long_q ? 8'd127 : 8'd39;
    assign crc_last  = long_q ? 8'd134 : 8'd46;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        crc_d       = crc_q;
        long_d      = long_q;
        skip_d      = skip_q;
        ferr_d      = ferr_q;
        idx_d       = idx_q;
        data_d      = data_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WAIT;
                    long_d  = bus.long_rsp;
                    skip_d  = bus.skip_crc;
                    ferr_d  = 1'b0;
                    cnt_d   = 8'd0;
                    crc_d   = 7'd0;
                    sh_d    = '0;
                end
            end
            S_WAIT: begin
                if (bus.bit_en) begin
                    if (!bus.cmd_in) begin
                        // The start bit is 0. From a zero CRC it leaves the CRC
                        // at 0, so the CRC needs no update here in either mode.
                        state_d = S_DATA;
                        cnt_d   = 8'd1;
                        sh_d    = sh_shift;
                    end else if (cnt_q == TO_LAST) begin
                        state_d     = S_FIN;
                        idx_d       = '0;
                        data_d      = '0;
                        crc_err_d   = 1'b0;
                        frame_err_d = 1'b0;
                        timeout_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DATA: begin
                if (bus.bit_en) begin
                    sh_d  = sh_shift;
                    cnt_d = cnt_q + 8'd1;
                    // cnt_q == 1 means this strobe carries the transmission bit.
                    if (cnt_q == 8'd1) begin
                        ferr_d = ferr_q | bus.cmd_in;
                    end
                    // A long frame covers CID only; its first 8 bits stay outside the CRC.
                    if (!long_q || cnt_q >= 8'd8) begin
                        crc_d = crc_step;
                    end
                    if (cnt_q == data_last) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (bus.bit_en) begin
                    sh_d  = sh_shift;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == crc_last) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bus.bit_en) begin
                    state_d     = S_FIN;
                    sh_d        = sh_shift;
                    // The 7 received CRC bits are the newest bits in sh_q.
                    crc_err_d   = !skip_q && (crc_q != sh_q[6:0]);
                    frame_err_d = ferr_q | !bus.cmd_in;
                    timeout_d   = 1'b0;
                    if (long_q) begin
                        idx_d  = sh_shift[133:128];
                        data_d = sh_shift[127:0];
                    end else begin
                        idx_d  = sh_shift[45:40];
                        data_d = {96'b0, sh_shift[39:8]};
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            crc_q       <= '0;
            long_q      <= 1'b0;
            skip_q      <= 1'b0;
            ferr_q      <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            crc_q       <= crc_d;
            long_q      <= long_d;
            skip_q      <= skip_d;
            ferr_q      <= ferr_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // FIN is the done cycle. busy is already low there, so the host sees both
    // changes in the same cycle.
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign bus.done      = (state_q == S_FIN);
    assign bus.rsp_index = idx_q;
    assign bus.rsp_data  = data_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.timeout   = timeout_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_sd_cmd_rsp_rx.sv
// Testbench for sd_cmd_rsp_rx: directed SD response frames followed by
// randomized ones. Every frame is built from its fields. Expected results come
// from a CRC7 computed by polynomial long division and from the frame's field
// layout. A monitor compares them whenever done is seen.
module tb_sd_cmd_rsp_rx;
    localparam int W = 137;  // {timeout, frame_err, crc_err, index[5:0], data[127:0]}
    localparam logic [W-1:0] TO_REC = {1'b1, 1'b0, 1'b0, 6'b0, 128'b0};

    logic clk;
    logic rst_n;
    logic [2:0] state_dbg;
    int n_tests = 0;
    int n_fail = 0;
    int strobe_div = 4;
    int phase = 0;
    logic [W-1:0] exp_q[$];

    sd_cmd_rsp_rx_if bus();

    sd_cmd_rsp_rx #(.TIMEOUT(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .state_o(state_dbg)
    );

    // ---------------- clock / reset / strobe ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.bit_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.bit_en = (phase == 0);
            phase = (phase + 1 >= strobe_div) ? 0 : phase + 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got simulation still running, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [6:0] crc7(input logic [119:0] msg, input int n);
        logic [126:0] r;
        r = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] b;
        b = {2'b00, idx, arg};
        return {88'b0, b, crc7({80'b0, b}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] mk_long(input logic [119:0] cid);
        return {2'b00, 6'h3F, cid, crc7(cid, 120), 1'b1};
    endfunction

    function automatic logic [W-1:0] model(input logic [135:0] f, input logic lng, input logic skp);
        logic [5:0] idx;
        logic [127:0] d;
        logic ce, fe;
        if (lng) begin
            idx = f[133:128];
            d   = f[127:0];
            ce  = !skp && (crc7(f[127:8], 120) != f[7:1]);
            fe  = f[134] | !f[0];
        end else begin
            idx = f[45:40];
            d   = {96'b0, f[39:8]};
            ce  = !skp && (crc7({80'b0, f[47:8]}, 40) != f[7:1]);
            fe  = f[46] | !f[0];
        end
        return {1'b0, fe, ce, idx, d};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares against the oldest expectation on every done.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending response");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_index", {122'b0, bus.rsp_index}, {122'b0, e[133:128]});
                    check("rsp_data", bus.rsp_data, e[127:0]);
                    check("crc_err", {127'b0, bus.crc_err}, {127'b0, e[134]});
                    check("frame_err", {127'b0, bus.frame_err}, {127'b0, e[135]});
                    check("timeout", {127'b0, bus.timeout}, {127'b0, e[136]});
                end
            end
        end
    end

    // ---------------- driver tasks (all return at posedge+2) ----------------
    // Presents one bit for the next strobe. The line glitches randomly on
    // the cycles in between.
    task automatic send_bit(input logic b);
        bit sent;
        sent = 1'b0;
        while (!sent) begin
            if (bus.bit_en) begin
                bus.cmd_in = b;
                sent = 1'b1;
            end else begin
                bus.cmd_in = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #2;
        end
        bus.cmd_in = 1'b1;
    endtask

    task automatic issue_start(input logic lng, input logic skp);
        bus.cmd_in   = 1'b1;
        bus.start    = 1'b1;
        bus.long_rsp = lng;
        bus.skip_crc = skp;
        @(posedge clk);
        #2;
        bus.start    = 1'b0;
        bus.long_rsp = 1'($urandom_range(0, 1));
        bus.skip_crc = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 40) begin
            @(posedge clk);
            #2;
            c++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_wait: got %0d responses still pending after 40 cycles, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run_frame(input logic [135:0] f, input logic lng, input logic skp,
                             input int gap, input bit poke);
        int len;
        len = lng ? 136 : 48;
        exp_q.push_back(model(f, lng, skp));
        issue_start(lng, skp);
        if (poke) begin
            check("busy_before_poke", {127'b0, bus.busy}, 128'd1);
            bus.start    = 1'b1;
            bus.long_rsp = ~lng;
            bus.skip_crc = ~skp;
            @(posedge clk);
            #2;
            bus.start = 1'b0;
        end
        repeat (gap) send_bit(1'b1);
        for (int i = len - 1; i >= 0; i--) send_bit(f[i]);
        wait_drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [135:0] f;
        logic [127:0] rnd;
        logic lng, skp;
        int kind, pos;

        rst_n = 1'b0;
        bus.cmd_in = 1'b1;
        bus.start = 1'b0;
        bus.long_rsp = 1'b0;
        bus.skip_crc = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_busy", {127'b0, bus.busy}, 128'd0);
        check("reset_done", {127'b0, bus.done}, 128'd0);
        check("reset_crc_err", {127'b0, bus.crc_err}, 128'd0);
        check("reset_frame_err", {127'b0, bus.frame_err}, 128'd0);
        check("reset_timeout", {127'b0, bus.timeout}, 128'd0);
        check("reset_index", {122'b0, bus.rsp_index}, 128'd0);
        check("reset_data", bus.rsp_data, 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // R7, strobe every 4 cycles, start bit on the 5th strobe.
        strobe_div = 4;
        f = {88'b0, 48'h08000001AA13};
        run_frame(f, 1'b0, 1'b0, 4, 1'b0);
        check("r7_index", {122'b0, bus.rsp_index}, 128'h08);
        check("r7_arg", bus.rsp_data, 128'h000001AA);
        // Same frame with arg[0] flipped.
        f[8] = ~f[8];
        run_frame(f, 1'b0, 1'b0, 4, 1'b0);

        // Timeout: line stays high for all 64 strobes.
        exp_q.push_back(TO_REC);
        issue_start(1'b0, 1'b0);
        repeat (63) send_bit(1'b1);
        check("busy_before_timeout", {127'b0, bus.busy}, 128'd1);
        check("done_before_timeout", {127'b0, bus.done}, 128'd0);
        send_bit(1'b1);
        check("done_at_timeout", {127'b0, bus.done}, 128'd1);
        check("busy_at_timeout", {127'b0, bus.busy}, 128'd0);
        @(posedge clk);
        #2;
        check("done_after_timeout", {127'b0, bus.done}, 128'd0);
        check("busy_after_timeout", {127'b0, bus.busy}, 128'd0);
        check("timeout_held", {127'b0, bus.timeout}, 128'd1);
        wait_drain();

        // R2 with bit_en held high, then the same frame with a bad end bit.
        strobe_div = 1;
        rnd = {$urandom, $urandom, $urandom, $urandom};
        f = mk_long(rnd[119:0]);
        run_frame(f, 1'b1, 1'b0, 3, 1'b0);
        f[0] = 1'b0;
        run_frame(f, 1'b1, 1'b0, 3, 1'b0);

        // R3 with and without CRC checking.
        strobe_div = 2;
        f = {88'b0, 48'h3F00FF8000FF};
        run_frame(f, 1'b0, 1'b1, 2, 1'b0);
        check("r3_arg", bus.rsp_data, 128'h00FF8000);
        run_frame(f, 1'b0, 1'b0, 2, 1'b0);
        check("r3_crc_err_held", {127'b0, bus.crc_err}, 128'd1);

        // Abort mid-DATA with reset.
        f = {88'b0, 48'h08000001AA13};
        issue_start(1'b0, 1'b0);
        repeat (2) send_bit(1'b1);
        for (int i = 47; i >= 38; i--) send_bit(f[i]);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {127'b0, bus.busy}, 128'd0);
        check("abort_done", {127'b0, bus.done}, 128'd0);
        check("abort_crc_err", {127'b0, bus.crc_err}, 128'd0);
        check("abort_frame_err", {127'b0, bus.frame_err}, 128'd0);
        check("abort_timeout", {127'b0, bus.timeout}, 128'd0);
        check("abort_state", {125'b0, state_dbg}, 128'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        // Fresh R7 after reset, with a start pulse while busy.
        run_frame(f, 1'b0, 1'b0, 3, 1'b1);

        // Randomized frames with corruptions.
        for (int n = 0; n < 24; n++) begin
            strobe_div = $urandom_range(1, 4);
            lng = 1'($urandom_range(0, 1));
            skp = ($urandom_range(0, 3) == 0);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            f = lng ? mk_long(rnd[119:0]) : mk_short(rnd[37:32], rnd[31:0]);
            kind = $urandom_range(0, 4);
            case (kind)
                1: begin
                    pos = lng ? $urandom_range(8, 133) : $urandom_range(8, 45);
                    f[pos] = ~f[pos];
                end
                2: f[lng ? 134 : 46] = 1'b1;
                3: f[0] = 1'b0;
                4: begin
                    pos = $urandom_range(1, 7);
                    f[pos] = ~f[pos];
                end
                default: ;
            endcase
            run_frame(f, lng, skp, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
        end

        check("queue_empty_at_end", {96'b0, 32'(exp_q.size())}, 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
